dmem_mmio_resp: RTL

- Responder for the core's data-memory interface. Decodes each access to word RAM or a small MMIO register bank, which holds a GPIO output register and a free-running timer with compare/match flag.
- Read data is combinational, because the single-cycle hart consumes it in the same cycle. All writes commit on the rising clock edge under per-byte enables.
- Sits beside the instruction memory in the SoC top, wired directly to the core's Mem_* ports.

---
 rtl/dmem_mmio_resp.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_mmio_resp.sv
// Data-memory responder: word RAM plus a small MMIO bank (GPIO_OUT, free-running
// timer with compare/match). Reads are combinational for the single-cycle hart;
// writes commit on the rising edge under per-byte enables.
module dmem_mmio_resp #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int unsigned DWIDTH    = 32
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core_N,
  input  logic [31:0] Mem_Data_Addr,
  input  logic [31:0] Mem_Data_Write,
  input  logic [3:0]  Mem_Write_Ctrl,
  input  logic        Mem_Read_Ctrl,
  output logic [31:0] Mem_Data_Read,
  output logic        Bus_Err,
  output logic [31:0] Gpio_Out,
  output logic        Timer_Irq
);

  localparam int AW = $clog2(RAM_WORDS);

  // Register offsets within the 64-byte window, as word indices
  localparam logic [3:0] IDX_GPIO   = 4'd0;
  localparam logic [3:0] IDX_TIMER  = 4'd1;
  localparam logic [3:0] IDX_CTRL   = 4'd2;
  localparam logic [3:0] IDX_CMP    = 4'd3;
  localparam logic [3:0] IDX_STATUS = 4'd4;

  if (DWIDTH != 32) begin : g_bad_width
    $error("dmem_mmio_resp: only DWIDTH=32 is supported");
  end
  if ((RAM_WORDS < 16) || (RAM_WORDS > 65536) || ((1 << AW) != RAM_WORDS)) begin : g_bad_words
    $error("dmem_mmio_resp: RAM_WORDS must be a power of 2 in 16..65536");
  end
  if ((64'(RAM_WORDS) * 64'd4) > 64'(MMIO_BASE)) begin : g_overlap
    $error("dmem_mmio_resp: RAM window overlaps MMIO_BASE");
  end

  // Architectural state
  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] gpio_q,  gpio_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  ctrl_q,  ctrl_d;    // {IRQ_EN, CLR_ON_MATCH, EN}
  logic [31:0] cmp_q,   cmp_d;
  logic        match_q, match_d;
  logic        berr_q,  berr_d;

  // Decode
  logic          ram_hit, mmio_hit, wr_any, unmapped;
  logic [AW-1:0] ram_idx;
  logic [31:0]   mmio_off;
  logic [3:0]    reg_idx;
  logic          wr_gpio, wr_timer, wr_ctrl, wr_cmp, wr_status;
  logic          tmr_en, tmr_clr, tmr_eq, match_set, match_clr;
  logic [31:0]   rdata;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int n = 0; n < 4; n++) r[8*n +: 8] = be[n] ? new_v[8*n +: 8] : old_v[8*n +: 8];
    return r;
  endfunction

  // Address decode and per-register write strobes
  always_comb begin
    ram_hit   = (Mem_Data_Addr[31:AW+2] == '0);
    ram_idx   = Mem_Data_Addr[AW+1:2];
    mmio_off  = Mem_Data_Addr - MMIO_BASE;
    mmio_hit  = (Mem_Data_Addr >= MMIO_BASE) && (mmio_off < 32'h40);
    reg_idx   = mmio_off[5:2];
    wr_any    = |Mem_Write_Ctrl;
    unmapped  = (Mem_Read_Ctrl | wr_any) & ~ram_hit & ~mmio_hit;
    wr_gpio   = mmio_hit && wr_any && (reg_idx == IDX_GPIO);
    wr_timer  = mmio_hit && wr_any && (reg_idx == IDX_TIMER);
    wr_ctrl   = mmio_hit && wr_any && (reg_idx == IDX_CTRL);
    wr_cmp    = mmio_hit && wr_any && (reg_idx == IDX_CMP);
    wr_status = mmio_hit && wr_any && (reg_idx == IDX_STATUS);
  end

  // Combinational read mux; zero when not strobed or unmapped
  always_comb begin
    rdata = '0;
    if (Mem_Read_Ctrl) begin
      if (ram_hit) begin
        rdata = ram_q[ram_idx];
      end else if (mmio_hit) begin
        case (reg_idx)
          IDX_GPIO:   rdata = gpio_q;
          IDX_TIMER:  rdata = timer_q;
          IDX_CTRL:   rdata = {29'b0, ctrl_q};
          IDX_CMP:    rdata = cmp_q;
          IDX_STATUS: rdata = {31'b0, match_q};
          default:    rdata = '0;
        endcase
      end
    end
  end

  // Next-state for MMIO registers, timer and match flag
  always_comb begin
    tmr_en    = ctrl_q[0];
    tmr_clr   = ctrl_q[1];
    tmr_eq    = (timer_q == cmp_q);
    match_set = tmr_en && tmr_eq;   // pre-edge compare, ignores a same-cycle write
    match_clr = wr_status && Mem_Write_Ctrl[0] && Mem_Data_Write[0];

    gpio_d = wr_gpio ? merge_bytes(gpio_q, Mem_Data_Write, Mem_Write_Ctrl) : gpio_q;
    cmp_d  = wr_cmp  ? merge_bytes(cmp_q,  Mem_Data_Write, Mem_Write_Ctrl) : cmp_q;
    ctrl_d = (wr_ctrl && Mem_Write_Ctrl[0]) ? Mem_Data_Write[2:0] : ctrl_q;

    if (wr_timer)                  timer_d = merge_bytes(timer_q, Mem_Data_Write, Mem_Write_Ctrl);
    else if (match_set && tmr_clr) timer_d = '0;
    else if (tmr_en)               timer_d = timer_q + 32'd1;
    else                           timer_d = timer_q;

    // set beats clear when both land on the same edge
    if (match_set)      match_d = 1'b1;
    else if (match_clr) match_d = 1'b0;
    else                match_d = match_q;

    berr_d = unmapped;
  end

  // MMIO register bank and bus-error pulse
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      gpio_q  <= '0;
      timer_q <= '0;
      ctrl_q  <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      timer_q <= timer_d;
      ctrl_q  <= ctrl_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      berr_q  <= berr_d;
    end
  end

  // Byte-enabled RAM write; RAM is deliberately left unreset
  always_ff @(posedge Clk_Core) begin
    if (ram_hit) begin
      for (int n = 0; n < 4; n++) begin
        if (Mem_Write_Ctrl[n]) ram_q[ram_idx][8*n +: 8] <= Mem_Data_Write[8*n +: 8];
      end
    end
  end

  assign Mem_Data_Read = rdata;
  assign Bus_Err       = berr_q;
  assign Gpio_Out      = gpio_q;
  assign Timer_Irq     = match_q & ctrl_q[2];

endmodule
